uart_rx_9bit: RTL and testbench

- Serial receiver feeding the request path. Deserialises 9-data-bit, 1-stop, no-parity frames from the ground-link `rx` line.
- Delivers each 9-bit word as `data` with a one-cycle `done` strobe, which is the write-enable of the controller's request FIFO.
- Flags malformed frames on `framing_error`.
- Uses 16x oversampling with a majority-vote decision at mid-bit.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 45 ++++
 rtl/uart_rx_9bit.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_9bit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the 9-bit UART receiver and its matching transmitter.
//   - rx_state_t : receiver FSM state encoding
//   - FRAME_BITS : data bits per frame
//   - STOP_LEVEL : line level of a valid stop bit
//   - maj3()     : 2-of-3 majority vote used at mid-bit
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam int   FRAME_BITS = 9;
   localparam logic STOP_LEVEL = 1'b1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Oversample tick generator. Counts 0..DIV-1 and raises `tick` for one clock
//   while the count sits at DIV-1. Holding `clear` high parks the counter at 0
//   and suppresses the tick, so the first tick after release arrives DIV clocks
//   later.
//   Ports:
//     clock  in  system clock, rising edge
//     reset  in  asynchronous active-low reset
//     clear  in  synchronous counter clear / hold
//     tick   out one-cycle sample strobe
// -----------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(DIV) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         tick  = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx_9bit.sv
// -----------------------------------------------------------------------------
// uart_rx_9bit
//   Receiver for 9-data-bit, 1-stop, no-parity frames, 16x (OVERSAMPLE)
//   oversampled with a 3-sample majority vote at mid-bit.
//   Ports:
//     clock          in  system clock, rising edge
//     reset          in  asynchronous active-low reset
//     rx             in  asynchronous serial line, idle high
//     data[8:0]      out last good word, stable between done pulses
//     done           out one-cycle pulse, data valid this cycle
//     framing_error  out one-cycle pulse, stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx_9bit
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 25_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rx,
   output logic [FRAME_BITS-1:0] data,
   output logic                  done,
   output logic                  framing_error
);

   localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int SW  = $clog2(OVERSAMPLE);

   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [3:0]    B_LAST = 4'(FRAME_BITS - 1);

   rx_state_t             state_q, state_d;
   logic                  rx_meta_q, rx_meta_d;
   logic                  rx_s_q, rx_s_d;
   logic [SW-1:0]         s_q, s_d;
   logic [3:0]            b_q, b_d;
   logic                  v0_q, v0_d;
   logic                  v1_q, v1_d;
   logic [FRAME_BITS-1:0] sr_q, sr_d;
   logic [FRAME_BITS-1:0] data_q, data_d;
   logic                  done_q, done_d;
   logic                  ferr_q, ferr_d;

   logic tick;
   logic tick_clear;
   logic vote;

   // Tick counter is held at zero throughout IDLE, which also clears it on
   // the transition into START.
   assign tick_clear = (state_q == IDLE);

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .clock (clock),
      .reset (reset),
      .clear (tick_clear),
      .tick  (tick)
   );

   // Two earlier samples plus the live one; only meaningful at s == S_V2.
   assign vote = maj3(v0_q, v1_q, rx_s_q);

   always_comb begin
      rx_meta_d = rx;
      rx_s_d    = rx_meta_q;
      state_d   = state_q;
      s_d       = s_q;
      b_d       = b_q;
      v0_d      = v0_q;
      v1_d      = v1_q;
      sr_d      = sr_q;
      data_d    = data_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;

      // Bit-timing sample counter; BREAK reuses s as its own high-run counter.
      if (tick && (state_q != BREAK)) begin
         s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
         if (s_q == S_V0) v0_d = rx_s_q;
         if (s_q == S_V1) v1_d = rx_s_q;
      end

      case (state_q)
         IDLE: begin
            s_d = '0;
            b_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            if (tick) begin
               if ((s_q == S_V2) && vote) begin
                  state_d = IDLE;
               end else if (s_q == S_LAST) begin
                  state_d = DATA;
                  b_d     = '0;
               end
            end
         end
         DATA: begin
            if (tick) begin
               // LSB arrives first, so after nine shifts d0 sits in bit 0.
               if (s_q == S_V2) sr_d = {vote, sr_q[FRAME_BITS-1:1]};
               if (s_q == S_LAST) begin
                  if (b_q == B_LAST) state_d = STOP;
                  else               b_d     = b_q + 1'b1;
               end
            end
         end
         STOP: begin
            // Decide at the vote rather than waiting out the stop bit, so a
            // start bit immediately following is not missed.
            if (tick && (s_q == S_V2)) begin
               if (vote == STOP_LEVEL) begin
                  data_d  = sr_q;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  s_d     = '0;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            // Needs OVERSAMPLE consecutive high ticks; any low restarts.
            if (!rx_s_q) begin
               s_d = '0;
            end else if (tick) begin
               if (s_q == S_LAST) state_d = IDLE;
               else               s_d     = s_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         s_q       <= '0;
         b_q       <= '0;
         v0_q      <= 1'b1;
         v1_q      <= 1'b1;
         sr_q      <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         s_q       <= s_d;
         b_q       <= b_d;
         v0_q      <= v0_d;
         v1_q      <= v1_d;
         sr_q      <= sr_d;
         data_q    <= data_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
      end
   end

   assign data          = data_q;
   assign done          = done_q;
   assign framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_9bit.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_9bit
//   Directed bench for uart_rx_9bit at CLK_HZ=640, BAUD=10, OVERSAMPLE=16
//   (DIV=4, 64 clocks per bit).
// -----------------------------------------------------------------------------
module tb_uart_rx_9bit;

   localparam int CLK_HZ   = 640;
   localparam int BAUD     = 10;
   localparam int OS       = 16;
   localparam int DIV      = 4;
   localparam int BIT_CLKS = OS * DIV;
   localparam int PERIOD   = 10;
   // Start edge to visible done: 2 synchroniser clocks, 1 clock to leave IDLE,
   // start + 9 data bits, then OS/2+2 ticks into the stop bit for the vote.
   localparam int EXP_LAT  = 3 + 10 * BIT_CLKS + (OS / 2 + 2) * DIV;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       rx    = 1'b1;
   logic [8:0] data;
   logic       done;
   logic       framing_error;

   int total = 0;
   int bad   = 0;

   int         done_cnt = 0;
   int         ferr_cnt = 0;
   int         both_cnt = 0;
   time        t_done   = 0;
   time        t_start  = 0;
   logic [8:0] got_q[$];

   uart_rx_9bit #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OS)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .rx            (rx),
      .data          (data),
      .done          (done),
      .framing_error (framing_error)
   );

   always #(PERIOD / 2) clock = ~clock;

   always @(negedge clock) begin
      if (done === 1'b1) begin
         done_cnt++;
         got_q.push_back(data);
         t_done = $time;
      end
      if (framing_error === 1'b1) ferr_cnt++;
      if ((done === 1'b1) && (framing_error === 1'b1)) both_cnt++;
   end

   // All stimulus changes happen 1 time unit after a rising edge.
   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (BIT_CLKS) @(posedge clock);
      #1;
   endtask

   task automatic send_frame(input logic [8:0] w, input logic stop_v);
      t_start = $time;
      drive_bit(1'b0);
      for (int i = 0; i < 9; i++) drive_bit(w[i]);
      drive_bit(stop_v);
   endtask

   task automatic test_reset;
      #2;
      total++;
      if (data !== 9'h000) begin bad++; $display("FAIL reset_data: got %h want 000", data); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++;
      if (framing_error !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", framing_error); end
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      idle(2000);
      total++;
      if (done_cnt !== 0) begin bad++; $display("FAIL idle_done: got %0d pulses want 0", done_cnt); end
      total++;
      if (ferr_cnt !== 0) begin bad++; $display("FAIL idle_ferr: got %0d pulses want 0", ferr_cnt); end
      total++;
      if (data !== 9'h000) begin bad++; $display("FAIL idle_data: got %h want 000", data); end
   endtask

   task automatic test_single;
      int  d0;
      int  lat;
      d0 = done_cnt;
      send_frame(9'h1A5, 1'b1);
      idle(20);
      total++;
      if (done_cnt - d0 !== 1) begin bad++; $display("FAIL single_count: got %0d pulses want 1", done_cnt - d0); end
      total++;
      if (data !== 9'h1A5) begin bad++; $display("FAIL single_data: got %h want 1a5", data); end
      lat = int'((t_done - t_start) / PERIOD);
      total++;
      if ((lat < EXP_LAT - 1) || (lat > EXP_LAT + 1)) begin
         bad++;
         $display("FAIL single_latency: got %0d clocks want %0d +-1", lat, EXP_LAT);
      end
      total++;
      if (ferr_cnt !== 0) begin bad++; $display("FAIL single_ferr: got %0d pulses want 0", ferr_cnt); end
   endtask

   task automatic test_glitch;
      int d0;
      int f0;
      d0 = done_cnt;
      f0 = ferr_cnt;
      rx = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      idle(200);
      total++;
      if (done_cnt !== d0) begin bad++; $display("FAIL glitch_done: got %0d pulses want 0", done_cnt - d0); end
      total++;
      if (ferr_cnt !== f0) begin bad++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_cnt - f0); end
      total++;
      if (dut.state_q !== uart_pkg::IDLE) begin
         bad++;
         $display("FAIL glitch_state: got %0d want IDLE", dut.state_q);
      end
      send_frame(9'h0F3, 1'b1);
      idle(20);
      total++;
      if ((done_cnt - d0 !== 1) || (data !== 9'h0F3)) begin
         bad++;
         $display("FAIL glitch_next: got %0d pulses data %h want 1 pulse data 0f3", done_cnt - d0, data);
      end
   endtask

   task automatic test_framing;
      int d0;
      int f0;
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(9'h155, 1'b0);
      rx = 1'b0;
      repeat (300) @(posedge clock);
      #1;
      idle(100);
      total++;
      if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL frame_ferr: got %0d pulses want 1", ferr_cnt - f0); end
      total++;
      if (done_cnt !== d0) begin bad++; $display("FAIL frame_done: got %0d pulses want 0", done_cnt - d0); end
      total++;
      if (data !== 9'h0F3) begin bad++; $display("FAIL frame_hold: got %h want 0f3", data); end
      send_frame(9'h0AA, 1'b1);
      idle(20);
      total++;
      if ((done_cnt - d0 !== 1) || (data !== 9'h0AA)) begin
         bad++;
         $display("FAIL frame_next: got %0d pulses data %h want 1 pulse data 0aa", done_cnt - d0, data);
      end
   endtask

   task automatic test_back_to_back;
      logic [8:0] exp_w [3];
      int         d0;
      exp_w[0] = 9'h001;
      exp_w[1] = 9'h1FF;
      exp_w[2] = 9'h100;
      got_q.delete();
      d0 = done_cnt;
      for (int i = 0; i < 3; i++) send_frame(exp_w[i], 1'b1);
      idle(20);
      total++;
      if (done_cnt - d0 !== 3) begin bad++; $display("FAIL b2b_count: got %0d pulses want 3", done_cnt - d0); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (got_q.size() <= i) begin
            bad++;
            $display("FAIL b2b_word%0d: got none want %h", i, exp_w[i]);
         end else if (got_q[i] !== exp_w[i]) begin
            bad++;
            $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [8:0] w;
      int         d0;
      int         f0;
      w  = 9'h0C3;
      d0 = done_cnt;
      f0 = ferr_cnt;
      t_start = $time;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(w[i]);
      rx = w[4];
      repeat (30) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      total++;
      if (data !== 9'h000) begin bad++; $display("FAIL rstmid_data: got %h want 000", data); end
      total++;
      if ((done !== 1'b0) || (framing_error !== 1'b0)) begin
         bad++;
         $display("FAIL rstmid_pulses: got done=%b ferr=%b want 0 0", done, framing_error);
      end
      rx = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      idle(1000);
      total++;
      if ((done_cnt !== d0) || (ferr_cnt !== f0)) begin
         bad++;
         $display("FAIL rstmid_partial: got done %0d ferr %0d want 0 0", done_cnt - d0, ferr_cnt - f0);
      end
      send_frame(9'h03C, 1'b1);
      idle(20);
      total++;
      if ((done_cnt - d0 !== 1) || (data !== 9'h03C)) begin
         bad++;
         $display("FAIL rstmid_next: got %0d pulses data %h want 1 pulse data 03c", done_cnt - d0, data);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_framing();
      test_back_to_back();
      test_reset_mid();
      total++;
      if (both_cnt !== 0) begin bad++; $display("FAIL exclusive: got %0d overlapping cycles want 0", both_cnt); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
